// File: rtl/fifo_stream_drain.sv
// Drains a non-FWFT FIFO read port into a valid/ready stream with m_last framing.
// Define FIFO_STREAM_DRAIN_STATS_EN to add the stat_words / stat_stall counters.
module fifo_stream_drain #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned PKT_LEN   = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fifo_rd_read,
    input  logic [WIDTH-1:0] fifo_rd_dout,
    input  logic             fifo_rd_empty,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last
`ifdef FIFO_STREAM_DRAIN_STATS_EN
    ,
    output logic [31:0]      stat_words,
    output logic [31:0]      stat_stall
`endif
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned KW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [KW-1:0] LAST_IDX = (PKT_LEN > 0) ? KW'(PKT_LEN - 1) : '0;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [RD_LAT-1:0] pipe;
    logic [CW-1:0]    inflight;
    logic [KW-1:0]    pkt_cnt;
    logic             push;
    logic             pop;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(pipe[i]);
        end
    end

    // Credit rule: words already requested count against buffer space.
    assign fifo_rd_read = !rst && !fifo_rd_empty &&
                          (({1'b0, count} + {1'b0, inflight}) < DEPTH_C);

    assign push    = pipe[RD_LAT-1];
    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;
    assign m_data  = mem[head];
    assign m_last  = (PKT_LEN != 0) && m_valid && (pkt_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= fifo_rd_read;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[tail] <= fifo_rd_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if (pop && (PKT_LEN != 0)) begin
            pkt_cnt <= (pkt_cnt == LAST_IDX) ? '0 : pkt_cnt + 1'b1;
        end
    end

`ifdef FIFO_STREAM_DRAIN_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words <= '0;
            stat_stall <= '0;
        end else begin
            if (pop && (stat_words != '1)) begin
                stat_words <= stat_words + 1'b1;
            end
            if (m_valid && !m_ready && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: RD_LAT=1 and RD_LAT=2 instances in lockstep against a queue-based FIFO and scoreboard.
module tb_fifo_stream_drain;

    localparam int NL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mready;
    logic        rd     [NL];
    logic [15:0] dout   [NL];
    logic        empty  [NL];
    logic [15:0] mdata  [NL];
    logic        mvalid [NL];
    logic        mlast  [NL];
`ifdef FIFO_STREAM_DRAIN_STATS_EN
    logic [31:0] sw [NL];
    logic [31:0] ss [NL];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : lane
        fifo_stream_drain #(
            .WIDTH(16), .RD_LAT(g + 1), .BUF_DEPTH(4), .PKT_LEN(8)
        ) dut (
            .clk(clk),
            .rst(rst),
            .fifo_rd_read(rd[g]),
            .fifo_rd_dout(dout[g]),
            .fifo_rd_empty(empty[g]),
            .m_data(mdata[g]),
            .m_valid(mvalid[g]),
            .m_ready(mready),
            .m_last(mlast[g])
`ifdef FIFO_STREAM_DRAIN_STATS_EN
            ,
            .stat_words(sw[g]),
            .stat_stall(ss[g])
`endif
        );
    end

    // Reference: FIFO contents, words read but not yet delivered, transfer bookkeeping.
    logic [15:0] fq    [NL][$];
    logic [15:0] exp_q [NL][$];
    logic [15:0] s1    [NL];
    logic        s1v   [NL];
    logic        rd_pend [NL];
    logic        rst_pend;
    logic        prev_stall [NL];
    logic [15:0] prev_data  [NL];
    logic        prev_last  [NL];
    int unsigned xcnt [NL], lasts [NL], reads [NL], stalls [NL];
    int          first_rd [NL], first_val [NL], first_x [NL], last_x [NL];
    int unsigned cyc;
    int unsigned checks, errors;

    typedef struct {
        int unsigned nwords;
        int unsigned mode;      // 0 ready=1, 1 toggle, 2 ten stall cycles first, 3 random
        int unsigned exp_xfers;
        int unsigned exp_lasts;
        bit          chk_timing;
    } vec_t;

    task automatic chk_eq(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d: got %0h expected %0h", name, l, act, exp);
        end
    endtask

    task automatic chk_le(input string name, input int l, input int unsigned act, input int unsigned lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s lane%0d: got %0d expected at most %0d", name, l, act, lim);
        end
    endtask

    task automatic monitor();
        for (int l = 0; l < NL; l++) begin
            if (rd[l]) begin
                chk_eq("read_while_empty", l, 32'(empty[l]), 32'd0);
                chk_le("credit", l, exp_q[l].size(), 3);
                reads[l]++;
                if (first_rd[l] < 0) first_rd[l] = int'(cyc);
            end
            if (mvalid[l] && first_val[l] < 0 && !rst) first_val[l] = int'(cyc);
            if (prev_stall[l]) begin
                chk_eq("stall_valid", l, 32'(mvalid[l]), 32'd1);
                chk_eq("stall_data", l, 32'(mdata[l]), 32'(prev_data[l]));
                chk_eq("stall_last", l, 32'(mlast[l]), 32'(prev_last[l]));
            end
            if (!rst && mvalid[l] && mready) begin
                if (exp_q[l].size() == 0) begin
                    chk_eq("unexpected_word", l, 32'(mdata[l]), 32'hFFFF_FFFF);
                end else begin
                    chk_eq("data", l, 32'(mdata[l]), 32'(exp_q[l].pop_front()));
                end
                chk_eq("last", l, 32'(mlast[l]), 32'((xcnt[l] % 8) == 7));
                if (mlast[l]) lasts[l]++;
                if (first_x[l] < 0) first_x[l] = int'(cyc);
                last_x[l] = int'(cyc);
                xcnt[l]++;
            end else if (!rst && mvalid[l]) begin
                stalls[l]++;
            end
            prev_stall[l] = !rst && mvalid[l] && !mready;
            prev_data[l]  = mdata[l];
            prev_last[l]  = mlast[l];
            rd_pend[l]    = rd[l];
        end
        rst_pend = rst;
    endtask

    task automatic cycle();
        logic [15:0] w;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        for (int l = 0; l < NL; l++) begin
            if (rst_pend) begin
                exp_q[l].delete();
                xcnt[l] = 0;
            end
            w = 16'hDEAD;
            if (rd_pend[l] && fq[l].size() != 0) begin
                w = fq[l].pop_front();
                exp_q[l].push_back(w);
            end
            if (l == 0) begin
                if (rd_pend[l]) dout[l] = w;
            end else begin
                if (s1v[l]) dout[l] = s1[l];
                s1[l]  = w;
                s1v[l] = rd_pend[l];
            end
            empty[l] = (fq[l].size() == 0);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        for (int l = 0; l < NL; l++) begin
            fq[l].push_back(w);
            empty[l] = 1'b0;
        end
    endtask

    task automatic clear_counts();
        for (int l = 0; l < NL; l++) begin
            lasts[l] = 0; reads[l] = 0; stalls[l] = 0;
            first_rd[l] = -1; first_val[l] = -1; first_x[l] = -1; last_x[l] = -1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mready = 1'b0;
        cycle();
        for (int l = 0; l < NL; l++) begin
            chk_eq("rst_valid", l, 32'(mvalid[l]), 32'd0);
            chk_eq("rst_last", l, 32'(mlast[l]), 32'd0);
            chk_eq("rst_read", l, 32'(rd[l]), 32'd0);
`ifdef FIFO_STREAM_DRAIN_STATS_EN
            chk_eq("rst_stat_words", l, sw[l], 32'd0);
            chk_eq("rst_stat_stall", l, ss[l], 32'd0);
`endif
        end
        cycle();
        rst = 1'b0;
        clear_counts();
    endtask

    vec_t vecs [5];

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst = 1'b1; mready = 1'b0; rst_pend = 1'b1;
        for (int l = 0; l < NL; l++) begin
            empty[l] = 1'b1; dout[l] = '0; s1[l] = '0; s1v[l] = 1'b0;
            rd_pend[l] = 1'b0; prev_stall[l] = 1'b0; xcnt[l] = 0;
        end
        clear_counts();

        vecs[0] = '{16, 0, 16, 2, 1'b1};
        vecs[1] = '{16, 2, 16, 2, 1'b0};
        vecs[2] = '{3,  0, 3,  0, 1'b0};
        vecs[3] = '{20, 1, 20, 2, 1'b0};
        vecs[4] = '{40, 3, 40, 5, 1'b0};

        for (int v = 0; v < 5; v++) begin
            int unsigned pushed;
            int unsigned k;
            do_reset();
            pushed = 0;
            if (vecs[v].mode != 3) begin
                for (int unsigned i = 1; i <= vecs[v].nwords; i++) push_word(16'(i));
                pushed = vecs[v].nwords;
            end
            k = 0;
            while (k < 1000 && !(pushed == vecs[v].nwords &&
                   xcnt[0] == vecs[v].nwords && xcnt[1] == vecs[v].nwords)) begin
                case (vecs[v].mode)
                    0: mready = 1'b1;
                    1: mready = (cyc % 2 == 0);
                    2: mready = (k >= 10);
                    default: begin
                        mready = ($urandom_range(0, 2) != 0);
                        if (pushed < vecs[v].nwords && $urandom_range(0, 3) != 0) begin
                            push_word(16'($urandom));
                            pushed++;
                        end
                    end
                endcase
                if (vecs[v].mode == 2 && k == 10) begin
                    for (int l = 0; l < NL; l++) begin
                        chk_le("stall_reads", l, reads[l], 4);
                        chk_eq("stall_head", l, 32'(mdata[l]), 32'h0001);
                    end
                end
                cycle();
                k++;
            end
            for (int l = 0; l < NL; l++) begin
                chk_eq("xfers", l, xcnt[l], vecs[v].exp_xfers);
                chk_eq("lasts", l, lasts[l], vecs[v].exp_lasts);
                chk_eq("reads", l, reads[l], vecs[v].exp_xfers);
                if (vecs[v].chk_timing) begin
                    chk_eq("first_latency", l, 32'(first_val[l] - first_rd[l]), 32'(l + 2));
                    chk_eq("burst_cycles", l, 32'(last_x[l] - first_x[l] + 1), vecs[v].exp_xfers);
                end
            end
        end

        // FIFO runs dry after 3 words, then refills: packet position is retained.
        do_reset();
        for (int unsigned i = 1; i <= 3; i++) push_word(16'(16'h0A00 + i));
        mready = 1'b1;
        for (int k = 0; k < 12; k++) cycle();
        for (int l = 0; l < NL; l++) begin
            chk_eq("dry_valid", l, 32'(mvalid[l]), 32'd0);
            chk_eq("dry_reads", l, reads[l], 32'd3);
        end
        for (int unsigned i = 4; i <= 8; i++) push_word(16'(16'h0A00 + i));
        for (int k = 0; k < 12; k++) cycle();
        for (int l = 0; l < NL; l++) begin
            chk_eq("refill_xfers", l, xcnt[l], 32'd8);
            chk_eq("refill_lasts", l, lasts[l], 32'd1);
        end

        // Reset mid-stream: buffered words vanish, delivery resumes from the FIFO.
        do_reset();
        for (int unsigned i = 0; i < 24; i++) push_word(16'(16'h0200 + i));
        mready = 1'b1;
        for (int k = 0; k < 50 && xcnt[0] < 5; k++) cycle();
        chk_eq("pre_reset_xfers", 0, xcnt[0], 32'd5);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int l = 0; l < NL; l++) chk_eq("post_reset_valid", l, 32'(mvalid[l]), 32'd0);
        clear_counts();
        for (int k = 0; k < 60 && (xcnt[0] < 8 || xcnt[1] < 8); k++) cycle();
        for (int l = 0; l < NL; l++) begin
            chk_eq("post_reset_xfers", l, 32'(xcnt[l] >= 8), 32'd1);
            chk_eq("post_reset_lasts", l, lasts[l], 32'd1);
        end

`ifdef FIFO_STREAM_DRAIN_STATS_EN
        do_reset();
        for (int unsigned i = 1; i <= 16; i++) push_word(16'(i));
        mready = 1'b0;
        for (int k = 0; k < 10 && !(mvalid[0] && mvalid[1]); k++) cycle();
        for (int k = 0; k < 10; k++) cycle();
        mready = 1'b1;
        for (int k = 0; k < 60 && (xcnt[0] < 16 || xcnt[1] < 16); k++) cycle();
        for (int l = 0; l < NL; l++) begin
            chk_eq("stat_words", l, sw[l], 32'd16);
            chk_eq("stat_stall", l, ss[l], stalls[l]);
            chk_le("stat_stall_min", l, 10, ss[l]);
        end
        do_reset();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
